// File: rtl/display_fb_arbiter_if.sv
// Bundles every requester and RAM-side signal of display_fb_arbiter.
//   d_*   : display refresh read strobe, address and returned byte
//   wr_*  : pixel writer req/ack handshake
//   clr_* : full-screen clear strobe, fill value and busy flag
//   mem_* : single-port synchronous framebuffer RAM
// slave modport: the arbiter. master modport: the requesters plus the RAM.
interface display_fb_arbiter_if #(
  parameter int unsigned PAGES   = 8,
  parameter int unsigned COLUMNS = 128,
  parameter int unsigned ADDR_W  = 10
);
  localparam int unsigned PageW = $clog2(PAGES);
  localparam int unsigned ColW  = $clog2(COLUMNS);

  logic              d_read;
  logic [PageW-1:0]  d_page_idx;
  logic [ColW-1:0]   d_column_idx;
  logic [7:0]        d_data;
  logic              d_data_ready;

  logic              wr_req;
  logic [PageW-1:0]  wr_page;
  logic [ColW-1:0]   wr_column;
  logic [7:0]        wr_byte;
  logic              wr_ack;

  logic              clr_req;
  logic [7:0]        clr_value;
  logic              clr_busy;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  d_read, d_page_idx, d_column_idx,
    input  wr_req, wr_page, wr_column, wr_byte,
    input  clr_req, clr_value,
    input  mem_rdata,
    output d_data, d_data_ready, wr_ack, clr_busy,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output d_read, d_page_idx, d_column_idx,
    output wr_req, wr_page, wr_column, wr_byte,
    output clr_req, clr_value,
    output mem_rdata,
    input  d_data, d_data_ready, wr_ack, clr_busy,
    input  mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/display_fb_arbiter.sv
// Framebuffer arbiter: owns the single-port PAGES*COLUMNS x 8 RAM and grants at most one
// access per cycle with fixed priority display read > pixel write > clear step.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, clears all outputs and aborts reads/clear
//   bus   : display_fb_arbiter_if.slave (display read, writer, clear, RAM signals)
// Address of a byte is {page, column}. Reads return three cycles after d_read; the RAM is
// synchronous with one cycle of read latency.
module display_fb_arbiter #(
  parameter int unsigned PAGES   = 8,
  parameter int unsigned COLUMNS = 128,
  parameter int unsigned ADDR_W  = 10
) (
  input logic                 clk,
  input logic                 rst_n,
  display_fb_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(PAGES * COLUMNS - 1);

  typedef enum logic [0:0] {StIdle, StClear} clr_state_e;

  // Read request latch
  logic              r_rd_pend;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              w_rd_req;
  logic              w_rd_gnt;
  logic              w_rd_pend_next;
  logic [ADDR_W-1:0] w_rd_addr;

  // Write / clear grants
  logic              w_wr_gnt;
  logic              w_clr_gnt;
  logic [ADDR_W-1:0] w_wr_addr;

  // Clear sequencer
  clr_state_e        r_state;
  clr_state_e        w_state_next;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ADDR_W-1:0] w_clr_cnt_next;
  logic [7:0]        r_fill;
  logic [7:0]        w_fill_next;

  // Read return pipeline and registered outputs
  logic              r_rd_v1;
  logic              r_rd_v2;
  logic [7:0]        r_d_data;
  logic              r_d_data_ready;
  logic              r_wr_ack;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [7:0]        r_mem_wdata;

  // A new d_read always supersedes a latched one (last wins).
  assign w_rd_req  = bus.d_read | r_rd_pend;
  assign w_rd_addr = bus.d_read ? {bus.d_page_idx, bus.d_column_idx} : r_rd_addr;
  // Reads sit at the top of the priority order, so a pending read is always granted in
  // the cycle it is seen and the pending flag never outlives a cycle.
  assign w_rd_gnt       = w_rd_req;
  assign w_rd_pend_next = w_rd_req & ~w_rd_gnt;

  assign w_wr_addr = {bus.wr_page, bus.wr_column};
  // The r_wr_ack term stops the still-asserted request being granted twice.
  assign w_wr_gnt  = ~w_rd_gnt & bus.wr_req & ~r_wr_ack;

  always_comb begin
    w_state_next   = r_state;
    w_clr_cnt_next = r_clr_cnt;
    w_fill_next    = r_fill;
    w_clr_gnt      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.clr_req) begin
          w_state_next   = StClear;
          w_clr_cnt_next = '0;
          w_fill_next    = bus.clr_value;
        end
      end
      StClear: begin
        if (bus.clr_req) begin
          // Restart: no step issued this cycle, sequence begins again at address 0.
          w_clr_cnt_next = '0;
          w_fill_next    = bus.clr_value;
        end else if (!w_rd_gnt && !w_wr_gnt) begin
          w_clr_gnt      = 1'b1;
          w_clr_cnt_next = r_clr_cnt + ADDR_W'(1);
          if (r_clr_cnt == LastAddr) begin
            w_state_next = StIdle;
          end
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_clr_cnt <= '0;
      r_fill    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_cnt <= w_clr_cnt_next;
      r_fill    <= w_fill_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend      <= 1'b0;
      r_rd_addr      <= '0;
      r_rd_v1        <= 1'b0;
      r_rd_v2        <= 1'b0;
      r_d_data       <= '0;
      r_d_data_ready <= 1'b0;
      r_wr_ack       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_we       <= 1'b0;
      r_mem_wdata    <= '0;
    end else begin
      r_rd_pend      <= w_rd_pend_next;
      r_rd_addr      <= w_rd_addr;
      // v1: address on the RAM bus, v2: RAM output valid, then the byte is registered out.
      r_rd_v1        <= w_rd_gnt;
      r_rd_v2        <= r_rd_v1;
      r_d_data_ready <= r_rd_v2;
      if (r_rd_v2) begin
        r_d_data <= bus.mem_rdata;
      end
      r_wr_ack <= w_wr_gnt;
      r_mem_we <= w_wr_gnt | w_clr_gnt;
      if (w_rd_gnt) begin
        r_mem_addr <= w_rd_addr;
      end else if (w_wr_gnt) begin
        r_mem_addr  <= w_wr_addr;
        r_mem_wdata <= bus.wr_byte;
      end else if (w_clr_gnt) begin
        r_mem_addr  <= r_clr_cnt;
        r_mem_wdata <= r_fill;
      end
    end
  end

  assign bus.d_data       = r_d_data;
  assign bus.d_data_ready = r_d_data_ready;
  assign bus.wr_ack       = r_wr_ack;
  assign bus.clr_busy     = (r_state == StClear);
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_we       = r_mem_we;
  assign bus.mem_wdata    = r_mem_wdata;

endmodule
